axi_mem_init: RTL
=================

# axi_mem_init

AXI4 initiator that fills a memory with a fixed 64-bit pattern, reads the range back to verify it, and then reports completion. It connects to the 64-bit AXI responder port of `axi_mem`, or to any AXI4 RAM slave, through the SoC RAM port. Its done and error flags drive the core's `i_ram_init_done` and `i_ram_init_error` inputs, which are currently tied off. It runs once, starting automatically when reset is released.

## Interface
Parameters:
- `ID_WIDTH`, default 6: width of the AWID and ARID fields.
- `MEM_SIZE`, default 32'h800: bytes to initialise. Must be a multiple of `BURST_LEN`*8.
- `BASE_ADDR`, default 32'h0: first byte address. Must be 8-byte aligned.
- `BURST_LEN`, default 16: beats per burst, range 1–256.
- `FILL`, default 64'h0: data written to every beat.

Ports. Clock and reset are decided as: one clock `clk`; reset `rst`, asynchronous and active-high.
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous reset, active-high.
- `o_awid`, `o_arid`, out, `ID_WIDTH`: constant 0.
- `o_awaddr`, `o_araddr`, out, 32: burst start address.
- `o_awlen`, `o_arlen`, out, 8: constant `BURST_LEN`-1.
- `o_awsize`, `o_arsize`, out, 3: constant 3'd3 (8 bytes per beat).
- `o_awburst`, `o_arburst`, out, 2: constant 2'b01 (INCR).
- `o_awvalid`, `i_awready`, `o_arvalid`, `i_arready`, 1 each: address handshakes.
- `o_wdata`, out, 64: always `FILL`.
- `o_wstrb`, out, 8: constant 8'hFF.
- `o_wlast`, `o_wvalid`, out, 1 each; `i_wready`, in, 1: write data channel.
- `i_bresp`, in, 2; `i_bvalid`, in, 1; `o_bready`, out, 1: write response channel.
- `i_rdata`, in, 64; `i_rresp`, in, 2; `i_rlast`, `i_rvalid`, in, 1 each; `o_rready`, out, 1: read data channel.
- `i_bid`, `i_rid`, in, `ID_WIDTH`: ignored.
- `o_init_done`, out, 1: sticky; set when verification has finished.
- `o_init_error`, out, 1: sticky; set on any response or data error.

## Operation
- FSM states: `WR_ADDR` → `WR_DATA` → `WR_RESP` → back to `WR_ADDR` for the next burst, or to `RD_ADDR` after the last write burst. Then `RD_ADDR` → `RD_DATA` → back to `RD_ADDR`, or to `DONE` after the last read burst. `DONE` is terminal until reset.
- Burst address register:
  - Starts at `BASE_ADDR`.
  - Adds `BURST_LEN`*8 after each burst completes. The 32-bit sum wraps modulo 2^32 with no check.
  - Reloads `BASE_ADDR` when the FSM enters `RD_ADDR` from `WR_RESP`.
- Burst counter: counts `MEM_SIZE`/(8*`BURST_LEN`) bursts per phase.
- Beat counter: 8 bits, counts 0 to `BURST_LEN`-1 within a burst.
- `WR_ADDR`: `o_awvalid`=1. Move on when `i_awready`.
- `WR_DATA`:
  - `o_wvalid`=1, and `o_wlast`=1 on beat `BURST_LEN`-1.
  - The beat advances when `i_wready`.
  - `o_wvalid` is never raised before the AW handshake completes.
- `WR_RESP`: `o_bready`=1. When `i_bvalid` and `i_bresp`≠2'b00, set `o_init_error`.
- `RD_ADDR`: `o_arvalid`=1. Move on when `i_arready`.
- `RD_DATA`:
  - `o_rready`=1. On each `i_rvalid`, compare `i_rdata` to `FILL`.
  - Set `o_init_error` on any of: data mismatch; `i_rresp`≠0; `i_rlast`=1 before beat `BURST_LEN`-1; `i_rlast`=0 on beat `BURST_LEN`-1.
  - The burst always ends after `BURST_LEN` beats, whatever `i_rlast` says.
- Errors never abort the sequence. `o_init_done` still asserts at the end of the read phase.
- Valid signals are stable: once `o_*valid` is raised, it and its payload are held until the matching ready is seen.
- The ready signals `o_bready`/`o_rready` depend only on the FSM state, never on `i_bvalid`/`i_rvalid`.

## Timing
- Reset values: every `o_*valid`, `o_*ready` and `o_wlast` is 0. `o_awaddr` and `o_araddr` equal `BASE_ADDR`. `o_init_done`=0 and `o_init_error`=0. The FSM is in `WR_ADDR`, so `o_awvalid` is 1 in the first cycle after `rst` falls.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Cycle counts with a zero-wait responder:
  - Write burst: 1 AW cycle + `BURST_LEN` W cycles + 1 B cycle.
  - Read burst: 1 AR cycle + `BURST_LEN` R cycles.
  - `o_init_done` rises the cycle after the final R beat.
  - With default parameters (16 bursts per phase), `o_init_done` rises 16·18 + 16·17 = 560 cycles after the first post-reset edge, i.e. at cycle 561.
- Each wait cycle on `i_*ready` or `i_*valid` adds exactly one cycle.
- An error flag is set one cycle after the offending handshake.
- `rst` asserted mid-burst clears all state and valids asynchronously. The full sequence restarts from `BASE_ADDR` on release, and the done and error flags are cleared.

## Test plan
- Default params, zero-wait BFM memory preloaded with 0xA5 bytes → after 561 cycles `o_init_done`=1, `o_init_error`=0, and all 256 words read back as 0.
- `FILL`=64'hDEADBEEF_0123_4567, `BURST_LEN`=4, `MEM_SIZE`=32'h100 → 8 write bursts at 0x00, 0x20, …, 0xE0, each with `o_awlen`=3 and `o_wlast` on the 4th beat; `o_init_done`=1 and `o_init_error`=0.
- BFM delays `i_awready`, `i_wready` and `i_rvalid` by 3 cycles at random → every valid and its payload held stable while stalled; done asserts; cycle count grows by exactly the number of inserted waits.
- BFM returns `i_bresp`=2'b10 on burst 2 → `o_init_error`=1 the next cycle; remaining bursts still issue; `o_init_done`=1 at end.
- BFM flips bit 5 of read beat 37, or asserts `i_rlast` on beat 14 of a 16-beat burst → `o_init_error`=1; the read phase still completes 16 beats per burst.
- `rst` pulsed during beat 7 of write burst 3 → `o_wvalid`=0 immediately; after release `o_awaddr`=`BASE_ADDR`, the full 561-cycle sequence repeats, and the flags end 1/0.

Source files
------------

// File: rtl/axi_mem_init.sv
// AXI4 initiator that fills a memory range with a constant 64-bit pattern, reads it back to
// verify it, and then raises sticky done/error flags. It runs once after every reset release.
module axi_mem_init #(
  parameter int unsigned ID_WIDTH  = 6,
  parameter logic [31:0] MEM_SIZE  = 32'h800,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned BURST_LEN = 16,
  parameter logic [63:0] FILL      = 64'h0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [31:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready,
  output logic                o_init_done,
  output logic                o_init_error
);

  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);
  localparam logic [31:0] LAST_BURST  = (MEM_SIZE / BURST_BYTES) - 32'd1;

  typedef enum logic [2:0] {
    WR_ADDR = 3'd0,
    WR_DATA = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] burst_q, burst_d;
  logic [31:0] addr_q, addr_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        wlast_q, wlast_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;

  // Response IDs carry no information for a single-ID initiator.
  logic ids_unused;
  assign ids_unused = ^{i_bid, i_rid};

  // A read beat is bad on wrong data, a non-OKAY response, or RLAST disagreeing with the beat count.
  function automatic logic read_beat_bad(input logic [63:0] data, input logic [1:0] resp,
                                         input logic last, input logic final_beat);
    return (data != FILL) || (resp != 2'b00) || (last != final_beat);
  endfunction

  // Next-state, counters, flags and next-cycle channel controls.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    addr_d   = addr_q;
    done_d   = done_q;
    error_d  = error_q;
    case (state_q)
      WR_ADDR: begin
        if (awvalid_q && i_awready) begin
          state_d = WR_DATA;
          beat_d  = 8'd0;
        end else begin
          state_d = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (wvalid_q && i_wready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = WR_RESP;
            beat_d  = 8'd0;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      WR_RESP: begin
        if (bready_q && i_bvalid) begin
          error_d = error_q | (i_bresp != 2'b00);
          if (burst_q == LAST_BURST) begin
            state_d = RD_ADDR;
            burst_d = 32'd0;
            addr_d  = BASE_ADDR;
          end else begin
            state_d = WR_ADDR;
            burst_d = burst_q + 32'd1;
            addr_d  = addr_q + BURST_BYTES;
          end
        end else begin
          state_d = WR_RESP;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && i_arready) begin
          state_d = RD_DATA;
          beat_d  = 8'd0;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (rready_q && i_rvalid) begin
          error_d = error_q | read_beat_bad(i_rdata, i_rresp, i_rlast, beat_q == LAST_BEAT);
          // The burst length is fixed by our own ARLEN; RLAST is only checked, never obeyed.
          if (beat_q == LAST_BEAT) begin
            beat_d = 8'd0;
            addr_d = addr_q + BURST_BYTES;
            if (burst_q == LAST_BURST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RD_ADDR;
              burst_d = burst_q + 32'd1;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end else begin
          state_d = RD_DATA;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = WR_ADDR;
      end
    endcase
    awvalid_d = (state_d == WR_ADDR);
    wvalid_d  = (state_d == WR_DATA);
    wlast_d   = (state_d == WR_DATA) && (beat_d == LAST_BEAT);
    bready_d  = (state_d == WR_RESP);
    arvalid_d = (state_d == RD_ADDR);
    rready_d  = (state_d == RD_DATA);
  end

  // State, counters, flags and registered channel controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WR_ADDR;
      beat_q    <= 8'd0;
      burst_q   <= 32'd0;
      addr_q    <= BASE_ADDR;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      error_q   <= error_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign o_awid       = {ID_WIDTH{1'b0}};
  assign o_arid       = {ID_WIDTH{1'b0}};
  assign o_awaddr     = addr_q;
  assign o_araddr     = addr_q;
  assign o_awlen      = LAST_BEAT;
  assign o_arlen      = LAST_BEAT;
  assign o_awsize     = 3'd3;
  assign o_arsize     = 3'd3;
  assign o_awburst    = 2'b01;
  assign o_arburst    = 2'b01;
  assign o_awvalid    = awvalid_q;
  assign o_wdata      = FILL;
  assign o_wstrb      = 8'hFF;
  assign o_wlast      = wlast_q;
  assign o_wvalid     = wvalid_q;
  assign o_bready     = bready_q;
  assign o_arvalid    = arvalid_q;
  assign o_rready     = rready_q;
  assign o_init_done  = done_q;
  assign o_init_error = error_q;

endmodule
